// File: rtl/imem_loader_if.sv
// imem_loader_if: byte-stream, instruction-memory write and core-control signals of the boot loader.
// master = stream source / controller side, slave = loader side.
// Ports: start/len/byte_in/byte_valid in; byte_ready, imem_*, cpu_hold, done, err, words_loaded out.
interface imem_loader_if #(
   parameter int ADDR_W = 16
);
   logic              start;
   logic [ADDR_W-1:0] len;
   logic [7:0]        byte_in;
   logic              byte_valid;
   logic              byte_ready;
   logic              imem_we;
   logic [ADDR_W-1:0] imem_addr;
   logic [15:0]       imem_data;
   logic              cpu_hold;
   logic              done;
   logic              err;
   logic [ADDR_W-1:0] words_loaded;

   modport master (
      output start, len, byte_in, byte_valid,
      input  byte_ready, imem_we, imem_addr, imem_data, cpu_hold, done, err, words_loaded
   );

   modport slave (
      input  start, len, byte_in, byte_valid,
      output byte_ready, imem_we, imem_addr, imem_data, cpu_hold, done, err, words_loaded
   );
endinterface

// File: rtl/imem_loader.sv
// imem_loader: assembles big-endian 16-bit words from a byte stream, writes them to imem from
// address 0, then checks a trailing 16-bit checksum; holds the core while loading.
// Latency: start -> byte_ready 1 cycle; 3 cycles per word at full rate; done 1 cycle after last byte.
// Backpressure: byte_ready is registered and depends only on state; the loader waits indefinitely
// with byte_valid low. Ports: clk, rst (async, active-high), bus (imem_loader_if.slave).
module imem_loader #(
   parameter int ADDR_W = 16
) (
   input  logic         clk,
   input  logic         rst,
   imem_loader_if.slave bus
);

   typedef enum logic [2:0] {
      S_IDLE,
      S_HI,
      S_LO,
      S_WR,
      S_CK_HI,
      S_CK_LO,
      S_FIN
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] len_q, len_d;
   logic [ADDR_W-1:0] wl_q, wl_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [7:0]        hi_q, hi_d;
   logic [15:0]       sum_q, sum_d;
   logic [15:0]       data_q, data_d;
   logic              we_q, we_d;
   logic              ready_q, ready_d;
   logic              hold_q, hold_d;
   logic              done_q, done_d;
   logic              err_q, err_d;

   logic              xfer;
   logic [ADDR_W-1:0] wl_inc;

   assign xfer   = ready_q & bus.byte_valid;
   assign wl_inc = wl_q + ADDR_W'(1);

   always_comb begin
      state_d = state_q;
      len_d   = len_q;
      wl_d    = wl_q;
      addr_d  = addr_q;
      hi_d    = hi_q;
      sum_d   = sum_q;
      data_d  = data_q;
      err_d   = err_q;
      we_d    = 1'b0;
      done_d  = 1'b0;

      case (state_q)
         S_IDLE: begin
            if (bus.start) begin
               len_d = bus.len;
               wl_d  = '0;
               sum_d = '0;
               err_d = 1'b0;
               state_d = (bus.len == '0) ? S_CK_HI : S_HI;
            end
         end
         S_HI: begin
            if (xfer) begin
               hi_d    = bus.byte_in;
               state_d = S_LO;
            end
         end
         S_LO: begin
            // Word, address and write enable are registered together so that
            // they are all stable for the single WR cycle.
            if (xfer) begin
               data_d  = {hi_q, bus.byte_in};
               addr_d  = wl_q;
               we_d    = 1'b1;
               state_d = S_WR;
            end
         end
         S_WR: begin
            wl_d    = wl_inc;
            sum_d   = sum_q + data_q;
            state_d = (wl_inc == len_q) ? S_CK_HI : S_HI;
         end
         S_CK_HI: begin
            if (xfer) begin
               hi_d    = bus.byte_in;
               state_d = S_CK_LO;
            end
         end
         S_CK_LO: begin
            // The verdict is registered on entry to FIN so err is already
            // valid in the same cycle as the done pulse.
            if (xfer) begin
               err_d   = ({hi_q, bus.byte_in} != sum_q);
               done_d  = 1'b1;
               state_d = S_FIN;
            end
         end
         S_FIN: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase

      // Registered decodes of the next state keep byte_valid off every output path.
      ready_d = (state_d == S_HI) || (state_d == S_LO) ||
                (state_d == S_CK_HI) || (state_d == S_CK_LO);
      hold_d  = (state_d != S_IDLE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q <= S_IDLE;
         len_q   <= '0;
         wl_q    <= '0;
         addr_q  <= '0;
         hi_q    <= '0;
         sum_q   <= '0;
         data_q  <= '0;
         we_q    <= 1'b0;
         ready_q <= 1'b0;
         hold_q  <= 1'b0;
         done_q  <= 1'b0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         len_q   <= len_d;
         wl_q    <= wl_d;
         addr_q  <= addr_d;
         hi_q    <= hi_d;
         sum_q   <= sum_d;
         data_q  <= data_d;
         we_q    <= we_d;
         ready_q <= ready_d;
         hold_q  <= hold_d;
         done_q  <= done_d;
         err_q   <= err_d;
      end
   end

   assign bus.byte_ready   = ready_q;
   assign bus.imem_we      = we_q;
   assign bus.imem_addr    = addr_q;
   assign bus.imem_data    = data_q;
   assign bus.cpu_hold     = hold_q;
   assign bus.done         = done_q;
   assign bus.err          = err_q;
   assign bus.words_loaded = wl_q;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed loads against a scoreboard of expected writes, hold window and
// checksum verdict, plus literal expectations per scenario.
// Clock period 10; inputs change 1 after the rising edge; outputs sampled on the falling edge.
module tb_imem_loader;
   logic clk = 1'b0;
   logic rst = 1'b1;

   imem_loader_if #(.ADDR_W(16)) bus ();
   imem_loader #(.ADDR_W(16)) dut (.clk(clk), .rst(rst), .bus(bus));

   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at t=%0t", name, act, exp, $time);
      end
   endtask

   // Driver-owned model inputs
   logic [15:0] lw [4];
   int          start_cnt = 0;
   int          exp_n     = 0;
   bit          err_pend  = 1'b0;
   bit          cont      = 1'b0;
   logic [31:0] exp_q [$];

   // Monitor-owned model state
   int          seen_start = 0;
   bit          in_load    = 1'b0;
   bit          err_exp    = 1'b0;
   int          hold_cnt   = 0;
   int          hold_last  = 0;
   int          done_cnt   = 0;
   int          wr_cnt     = 0;
   logic [15:0] wr_addr [256];
   logic [15:0] wr_data [256];
   logic [31:0] mon_e;

   function automatic bit outs_nonzero();
      return |{bus.byte_ready, bus.imem_we, bus.imem_addr, bus.imem_data,
               bus.cpu_hold, bus.done, bus.err, bus.words_loaded};
   endfunction

   always @(negedge clk) begin
      if (rst) begin
         in_load    = 1'b0;
         err_exp    = 1'b0;
         exp_q.delete();
         seen_start = start_cnt;
         chk("reset_outputs_nonzero", 32'(outs_nonzero()), 32'd0);
      end else begin
         if (seen_start != start_cnt) begin
            seen_start = start_cnt;
            in_load    = 1'b1;
            err_exp    = 1'b0;
            hold_cnt   = 0;
         end
         chk("cpu_hold", 32'(bus.cpu_hold), 32'(in_load));
         if (in_load) hold_cnt++;
         if (!in_load)
            chk("idle_ready_we_done", 32'({bus.byte_ready, bus.imem_we, bus.done}), 32'd0);
         if (bus.imem_we) begin
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL extra_write: got addr 0x%0h data 0x%0h expected no write at t=%0t",
                        bus.imem_addr, bus.imem_data, $time);
            end else begin
               mon_e = exp_q.pop_front();
               chk("write_addr", 32'(bus.imem_addr), 32'(mon_e[31:16]));
               chk("write_data", 32'(bus.imem_data), 32'(mon_e[15:0]));
            end
            wr_addr[wr_cnt % 256] = bus.imem_addr;
            wr_data[wr_cnt % 256] = bus.imem_data;
            wr_cnt++;
         end
         if (bus.done) begin
            chk("done_inside_load", 32'(in_load), 32'd1);
            chk("words_loaded_at_done", 32'(bus.words_loaded), 32'(exp_n));
            chk("writes_outstanding_at_done", 32'(exp_q.size()), 32'd0);
            if (cont) chk("hold_cycles", 32'(hold_cnt), 32'(3 * exp_n + 3));
            hold_last = hold_cnt;
            err_exp   = err_pend;
            in_load   = 1'b0;
            done_cnt++;
         end else begin
            chk("err_level", 32'(bus.err), 32'(err_exp));
         end
      end
   end

   task automatic send_byte(input logic [7:0] b, input bit stall);
      int t;
      if (stall) begin
         bus.byte_valid = 1'b0;
         repeat (2) @(negedge clk);
         chk("ready_while_stalled", 32'(bus.byte_ready), 32'd1);
      end else begin
         @(negedge clk);
      end
      bus.byte_in    = b;
      bus.byte_valid = 1'b1;
      t = 0;
      while (!bus.byte_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      if (!bus.byte_ready) begin
         chk("byte_ready_timeout", 32'(bus.byte_ready), 32'd1);
      end else begin
         @(posedge clk);
         #1;
      end
   endtask

   task automatic do_start(input int n);
      @(posedge clk);
      #1;
      bus.len   = 16'(n);
      bus.start = 1'b1;
      @(posedge clk);
      #1;
      bus.start = 1'b0;
      start_cnt++;
      chk("err_cleared_on_start", 32'(bus.err), 32'd0);
   endtask

   task automatic do_load(input int n, input logic [15:0] cks, input bit stall, input bit poke);
      logic [15:0] s;
      int d0;
      int t;
      s = 16'h0000;
      for (int i = 0; i < n; i++) begin
         exp_q.push_back({16'(i), lw[i]});
         s = s + lw[i];
      end
      exp_n    = n;
      err_pend = (cks != s);
      cont     = !stall;
      d0       = done_cnt;
      do_start(n);
      for (int i = 0; i < n; i++) begin
         send_byte(lw[i][15:8], stall);
         if (poke && i == 0) begin
            bus.start = 1'b1;
            bus.len   = 16'd5;
         end
         send_byte(lw[i][7:0], stall);
         bus.start = 1'b0;
      end
      send_byte(cks[15:8], stall);
      send_byte(cks[7:0], stall);
      bus.byte_valid = 1'b0;
      t = 0;
      while (done_cnt == d0 && t < 10) begin
         @(negedge clk);
         #1;
         t++;
      end
      chk("done_seen", 32'(done_cnt - d0), 32'd1);
      @(negedge clk);
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $display("CHECKS %0d ERRORS %0d", checks, errors + 1);
      $fatal(1);
   end

   int base;

   initial begin
      bus.start      = 1'b0;
      bus.len        = 16'd0;
      bus.byte_in    = 8'd0;
      bus.byte_valid = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_byte_ready", 32'(bus.byte_ready), 32'd0);
      chk("rst_cpu_hold", 32'(bus.cpu_hold), 32'd0);
      chk("rst_words_loaded", 32'(bus.words_loaded), 32'd0);
      chk("rst_err", 32'(bus.err), 32'd0);
      #2 rst = 1'b0;

      // Two-word load, good checksum
      lw[0] = 16'h1081;
      lw[1] = 16'h2205;
      base  = wr_cnt;
      do_load(2, 16'h3286, 1'b0, 1'b0);
      chk("l1_err", 32'(bus.err), 32'd0);
      chk("l1_words_loaded", 32'(bus.words_loaded), 32'd2);
      chk("l1_hold_cycles", 32'(hold_last), 32'd9);
      chk("l1_write_count", 32'(wr_cnt - base), 32'd2);
      chk("l1_wr0_data", 32'(wr_data[base]), 32'h1081);
      chk("l1_wr1_addr", 32'(wr_addr[base + 1]), 32'd1);
      chk("l1_wr1_data", 32'(wr_data[base + 1]), 32'h2205);

      // Bad checksum; err must persist while idle
      do_load(2, 16'h0000, 1'b0, 1'b0);
      chk("l2_err", 32'(bus.err), 32'd1);
      repeat (3) @(negedge clk);
      #1;
      chk("l2_err_held", 32'(bus.err), 32'd1);

      // Stalled stream, one word
      lw[0] = 16'hABCD;
      base  = wr_cnt;
      do_load(1, 16'hABCD, 1'b1, 1'b0);
      chk("stall_write_count", 32'(wr_cnt - base), 32'd1);
      chk("stall_wr_addr", 32'(wr_addr[base]), 32'd0);
      chk("stall_wr_data", 32'(wr_data[base]), 32'hABCD);
      chk("stall_err", 32'(bus.err), 32'd0);

      // len = 0, good then bad checksum
      base = wr_cnt;
      do_load(0, 16'h0000, 1'b0, 1'b0);
      chk("len0_no_write", 32'(wr_cnt - base), 32'd0);
      chk("len0_err", 32'(bus.err), 32'd0);
      chk("len0_hold_cycles", 32'(hold_last), 32'd3);
      do_load(0, 16'h0001, 1'b0, 1'b0);
      chk("len0_bad_err", 32'(bus.err), 32'd1);

      // Sum wraps to 0x0001; start pulsed mid-load is ignored
      lw[0] = 16'hFFFF;
      lw[1] = 16'h0002;
      base  = wr_cnt;
      do_load(2, 16'h0001, 1'b0, 1'b1);
      chk("wrap_err", 32'(bus.err), 32'd0);
      chk("wrap_words_loaded", 32'(bus.words_loaded), 32'd2);
      chk("wrap_write_count", 32'(wr_cnt - base), 32'd2);

      // Reset after the high byte of word 1
      lw[0] = 16'h1234;
      lw[1] = 16'h5678;
      exp_q.push_back({16'd0, 16'h1234});
      exp_q.push_back({16'd1, 16'h5678});
      exp_n    = 2;
      err_pend = 1'b0;
      cont     = 1'b0;
      base     = wr_cnt;
      do_start(2);
      send_byte(8'h12, 1'b0);
      send_byte(8'h34, 1'b0);
      send_byte(8'h56, 1'b0);
      bus.byte_valid = 1'b0;
      #2 rst = 1'b1;
      #1;
      chk("arst_byte_ready", 32'(bus.byte_ready), 32'd0);
      chk("arst_imem_we", 32'(bus.imem_we), 32'd0);
      chk("arst_imem_addr", 32'(bus.imem_addr), 32'd0);
      chk("arst_imem_data", 32'(bus.imem_data), 32'd0);
      chk("arst_cpu_hold", 32'(bus.cpu_hold), 32'd0);
      chk("arst_done", 32'(bus.done), 32'd0);
      chk("arst_err", 32'(bus.err), 32'd0);
      chk("arst_words_loaded", 32'(bus.words_loaded), 32'd0);
      @(negedge clk);
      #2 rst = 1'b0;
      repeat (4) @(negedge clk);
      #1;
      chk("arst_only_word0_written", 32'(wr_cnt - base), 32'd1);

      // Fresh load after reset restarts at address 0
      lw[0] = 16'h0BAD;
      lw[1] = 16'hF00D;
      base  = wr_cnt;
      do_load(2, 16'hFBBA, 1'b0, 1'b0);
      chk("fresh_wr0_addr", 32'(wr_addr[base]), 32'd0);
      chk("fresh_wr0_data", 32'(wr_data[base]), 32'h0BAD);
      chk("fresh_err", 32'(bus.err), 32'd0);
      chk("fresh_words_loaded", 32'(bus.words_loaded), 32'd2);

      repeat (2) @(negedge clk);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
